// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM encoding and address helpers for the SPI NOR flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDID = 8'h9E;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_BE   = 8'hC7;

  localparam int unsigned PAGE_SIZE   = 256;
  localparam int unsigned OFFSET_BITS = $clog2(PAGE_SIZE);
  localparam int unsigned ADDR_W      = 24;

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_CMD    = 8'b0000_0010,
    S_ADDR   = 8'b0000_0100,
    S_RDATA  = 8'b0000_1000,
    S_ID     = 8'b0001_0000,
    S_PROG   = 8'b0010_0000,
    S_WAITCS = 8'b0100_0000,
    S_BUSY   = 8'b1000_0000
  } state_t;

  // Base address of the sector containing a.
  function automatic logic [ADDR_W-1:0] sector_base(input logic [ADDR_W-1:0] a,
                                                    input int unsigned bits);
    logic [ADDR_W-1:0] mask;
    mask = ~((ADDR_W'(1) << bits) - ADDR_W'(1));
    return a & mask;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave bit engine: input synchronisers, edge detect, rx byte assembly, tx shifter.
module spi_slave_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic       cs_high,
  output logic       cs_fall_c,
  output logic       cs_rise_c,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       rx_partial_c,
  output logic       tx_done
);

  logic [2:0] sclk_s;
  logic [2:0] cs_s;
  logic [1:0] mosi_s;
  logic [2:0] bit_cnt;
  logic [2:0] tx_cnt;
  logic [7:0] tx_sr;
  logic       rise;
  logic       fall;

  assign rise         = sclk_s[1] & ~sclk_s[2];
  assign fall         = ~sclk_s[1] & sclk_s[2];
  assign cs_fall_c    = ~cs_s[1] & cs_s[2];
  assign cs_rise_c    = cs_s[1] & ~cs_s[2];
  assign cs_high      = cs_s[1];
  assign rx_partial_c = (bit_cnt != 3'd0);

  // Two-stage synchronisers plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_clk};
      cs_s   <= {cs_s[1:0], spi_cs};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      rx_data    <= 8'h00;
      byte_valid <= 1'b0;
    end else if (cs_s[1]) begin
      bit_cnt    <= 3'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (rise) begin
        rx_data    <= {rx_data[6:0], mosi_s[1]};
        bit_cnt    <= bit_cnt + 3'd1;
        byte_valid <= (bit_cnt == 3'd7);
      end
    end
  end

  // tx_done marks the fall that puts bit 0 of the loaded byte on miso.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr   <= 8'h00;
      tx_cnt  <= 3'd0;
      miso    <= 1'b0;
      tx_done <= 1'b0;
    end else if (cs_s[1]) begin
      tx_sr   <= 8'h00;
      tx_cnt  <= 3'd0;
      miso    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_load) begin
        tx_sr  <= tx_data;
        tx_cnt <= 3'd0;
      end else if (fall) begin
        miso    <= tx_sr[7];
        tx_sr   <= {tx_sr[6:0], 1'b0};
        tx_cnt  <= tx_cnt + 3'd1;
        tx_done <= (tx_cnt == 3'd7);
      end
    end
  end

endmodule

// File: rtl/spi_flash_responder.sv
// Serial NOR flash emulator: command decode, address/page tracking, write-enable latch, busy timer.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ID_BYTES         = 20,
  parameter int unsigned PROG_BUSY_CYCLES = 20000,
  parameter int unsigned SE_BUSY_CYCLES   = 50000000,
  parameter int unsigned BE_BUSY_CYCLES   = 65000000,
  parameter int unsigned SECTOR_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [8*ID_BYTES-1:0] flash_id,
  output logic [23:0]           mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_wr,
  output logic [7:0]            mem_wdata,
  output logic                  erase_req,
  output logic                  erase_all,
  output logic [23:0]           erase_addr,
  output logic                  wel,
  output logic                  busy
);

  localparam int unsigned ID_W = 8 * ID_BYTES;

  state_t            state, state_n;
  logic [7:0]        cmd, cmd_n;
  logic [23:0]       addr, addr_n;
  logic [1:0]        addr_cnt, addr_cnt_n;
  logic              pend_wel, pend_wel_n;
  logic              pend_se, pend_se_n;
  logic              pend_be, pend_be_n;
  logic              prog_seen, prog_seen_n;
  logic              wel_n, busy_n;
  logic [31:0]       busy_cnt, busy_cnt_n;
  logic [ID_W-1:0]   id_sr, id_sr_n;
  logic              id_ld, id_ld_n;
  logic              rd_q;
  logic [23:0]       mem_addr_n, erase_addr_n;
  logic              mem_rd_n, mem_wr_n, erase_req_n, erase_all_n;
  logic [7:0]        mem_wdata_n;

  logic              cs_high, cs_fall_c, cs_rise_c, rx_partial_c;
  logic              byte_valid, tx_done;
  logic [7:0]        rx_data;
  logic              tx_load_c;
  logic [7:0]        tx_data_c;

  spi_slave_shifter u_shifter (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .mosi         (mosi),
    .tx_load      (tx_load_c),
    .tx_data      (tx_data_c),
    .miso         (miso),
    .cs_high      (cs_high),
    .cs_fall_c    (cs_fall_c),
    .cs_rise_c    (cs_rise_c),
    .rx_data      (rx_data),
    .byte_valid   (byte_valid),
    .rx_partial_c (rx_partial_c),
    .tx_done      (tx_done)
  );

  // Read data arrives the cycle after mem_rd, so the shifter loads off the delayed strobe.
  always_comb begin
    tx_load_c = 1'b0;
    tx_data_c = 8'h00;
    if (state == S_ID && id_ld) begin
      tx_load_c = 1'b1;
      tx_data_c = id_sr[ID_W-1 -: 8];
    end else if (state == S_RDATA && rd_q) begin
      tx_load_c = 1'b1;
      tx_data_c = mem_rdata;
    end
  end

  always_comb begin
    state_n      = state;
    cmd_n        = cmd;
    addr_n       = addr;
    addr_cnt_n   = addr_cnt;
    pend_wel_n   = pend_wel;
    pend_se_n    = pend_se;
    pend_be_n    = pend_be;
    prog_seen_n  = prog_seen;
    wel_n        = wel;
    busy_n       = busy;
    busy_cnt_n   = busy_cnt;
    id_sr_n      = id_sr;
    id_ld_n      = 1'b0;
    mem_addr_n   = mem_addr;
    mem_rd_n     = 1'b0;
    mem_wr_n     = 1'b0;
    mem_wdata_n  = mem_wdata;
    erase_req_n  = 1'b0;
    erase_all_n  = erase_all;
    erase_addr_n = erase_addr;

    if (busy) begin
      busy_cnt_n = (busy_cnt > 32'd0) ? busy_cnt - 32'd1 : 32'd0;
      if (busy_cnt <= 32'd1) busy_n = 1'b0;
    end

    unique case (state)
      S_IDLE: begin
        if (cs_fall_c) begin
          state_n     = busy ? S_WAITCS : S_CMD;
          pend_wel_n  = 1'b0;
          pend_se_n   = 1'b0;
          pend_be_n   = 1'b0;
          prog_seen_n = 1'b0;
          addr_cnt_n  = 2'd0;
        end
      end
      S_CMD: begin
        if (byte_valid) begin
          cmd_n = rx_data;
          case (rx_data)
            CMD_WREN: begin
              pend_wel_n = 1'b1;
              state_n    = S_WAITCS;
            end
            CMD_RDID: begin
              id_sr_n = flash_id;
              id_ld_n = 1'b1;
              state_n = S_ID;
            end
            CMD_READ, CMD_PP, CMD_SE: begin
              addr_cnt_n = 2'd0;
              state_n    = S_ADDR;
            end
            CMD_BE: begin
              pend_be_n = 1'b1;
              state_n   = S_WAITCS;
            end
            default: state_n = S_WAITCS;
          endcase
        end
      end
      S_ADDR: begin
        if (byte_valid) begin
          addr_n     = {addr[15:0], rx_data};
          addr_cnt_n = addr_cnt + 2'd1;
          if (addr_cnt == 2'd2) begin
            case (cmd)
              CMD_READ: begin
                mem_rd_n   = 1'b1;
                mem_addr_n = {addr[15:0], rx_data};
                state_n    = S_RDATA;
              end
              CMD_PP:  state_n = S_PROG;
              CMD_SE: begin
                pend_se_n = 1'b1;
                state_n   = S_WAITCS;
              end
              default: state_n = S_WAITCS;
            endcase
          end
        end
      end
      S_RDATA: begin
        // Prefetch the next byte while bit 0 of the current one is on the wire.
        if (tx_done) begin
          addr_n     = addr + 24'd1;
          mem_addr_n = addr + 24'd1;
          mem_rd_n   = 1'b1;
        end
      end
      S_ID: begin
        if (id_ld) id_sr_n = id_sr << 8;
        if (tx_done) id_ld_n = 1'b1;
      end
      S_PROG: begin
        if (byte_valid && wel) begin
          mem_wr_n    = 1'b1;
          mem_wdata_n = rx_data;
          mem_addr_n  = addr;
          addr_n      = {addr[23:OFFSET_BITS], addr[OFFSET_BITS-1:0] + OFFSET_BITS'(1)};
          prog_seen_n = 1'b1;
        end
      end
      S_WAITCS: ;
      S_BUSY: begin
        if (!busy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Chip-select release ends the transaction; commits only on a whole-byte boundary.
    if (state != S_BUSY && cs_high) begin
      state_n = S_IDLE;
      id_ld_n = 1'b0;
      if (cs_rise_c && !rx_partial_c) begin
        if (pend_wel) wel_n = 1'b1;
        if (state == S_PROG && prog_seen && wel) begin
          wel_n      = 1'b0;
          busy_n     = 1'b1;
          busy_cnt_n = 32'(PROG_BUSY_CYCLES);
          state_n    = S_BUSY;
        end
        if (pend_se && wel) begin
          erase_req_n  = 1'b1;
          erase_all_n  = 1'b0;
          erase_addr_n = sector_base(addr, SECTOR_BITS);
          wel_n        = 1'b0;
          busy_n       = 1'b1;
          busy_cnt_n   = 32'(SE_BUSY_CYCLES);
          state_n      = S_BUSY;
        end
        if (pend_be && wel) begin
          erase_req_n  = 1'b1;
          erase_all_n  = 1'b1;
          erase_addr_n = 24'h000000;
          wel_n        = 1'b0;
          busy_n       = 1'b1;
          busy_cnt_n   = 32'(BE_BUSY_CYCLES);
          state_n      = S_BUSY;
        end
      end
      pend_wel_n = 1'b0;
      pend_se_n  = 1'b0;
      pend_be_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd        <= 8'h00;
      addr       <= 24'h000000;
      addr_cnt   <= 2'd0;
      pend_wel   <= 1'b0;
      pend_se    <= 1'b0;
      pend_be    <= 1'b0;
      prog_seen  <= 1'b0;
      wel        <= 1'b0;
      busy       <= 1'b0;
      busy_cnt   <= 32'd0;
      id_sr      <= '0;
      id_ld      <= 1'b0;
      rd_q       <= 1'b0;
      mem_addr   <= 24'h000000;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= 8'h00;
      erase_req  <= 1'b0;
      erase_all  <= 1'b0;
      erase_addr <= 24'h000000;
    end else begin
      state      <= state_n;
      cmd        <= cmd_n;
      addr       <= addr_n;
      addr_cnt   <= addr_cnt_n;
      pend_wel   <= pend_wel_n;
      pend_se    <= pend_se_n;
      pend_be    <= pend_be_n;
      prog_seen  <= prog_seen_n;
      wel        <= wel_n;
      busy       <= busy_n;
      busy_cnt   <= busy_cnt_n;
      id_sr      <= id_sr_n;
      id_ld      <= id_ld_n;
      rd_q       <= mem_rd;
      mem_addr   <= mem_addr_n;
      mem_rd     <= mem_rd_n;
      mem_wr     <= mem_wr_n;
      mem_wdata  <= mem_wdata_n;
      erase_req  <= erase_req_n;
      erase_all  <= erase_all_n;
      erase_addr <= erase_addr_n;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: an SPI master drives directed transactions,
// a monitor checks memory/erase strobes, busy pulse lengths and received miso bytes.
module tb_spi_flash_responder;

  localparam int unsigned ID_BYTES = 20;
  localparam int unsigned PROG_CYC = 20000;
  localparam int unsigned SE_CYC   = 3000;
  localparam int unsigned BE_CYC   = 2500;
  localparam int          HALF     = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  spi_clk, spi_cs, mosi;
  logic                  miso;
  logic [8*ID_BYTES-1:0] flash_id;
  logic [23:0]           mem_addr;
  logic                  mem_rd;
  logic [7:0]            mem_rdata = 8'h00;
  logic                  mem_wr;
  logic [7:0]            mem_wdata;
  logic                  erase_req, erase_all;
  logic [23:0]           erase_addr;
  logic                  wel, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_len;

  logic [7:0]  mem [int];
  logic [23:0] exp_rd [$];
  logic [31:0] exp_wr [$];
  logic [24:0] exp_er [$];
  int          exp_busy [$];
  logic [7:0]  exp_miso [$];
  logic [7:0]  got_miso [$];

  spi_flash_responder #(
    .ID_BYTES        (ID_BYTES),
    .PROG_BUSY_CYCLES(PROG_CYC),
    .SE_BUSY_CYCLES  (SE_CYC),
    .BE_BUSY_CYCLES  (BE_CYC),
    .SECTOR_BITS     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .mosi      (mosi),
    .miso      (miso),
    .flash_id  (flash_id),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .erase_req (erase_req),
    .erase_all (erase_all),
    .erase_addr(erase_addr),
    .wel       (wel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Backing store: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
    if (mem_wr) mem[int'(mem_addr)] = mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [63:0] got);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0h, nothing expected", name, got);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], miso};
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    xfer_bits(b, 8, r);
  endtask

  task automatic read_chk(input logic [7:0] exp);
    logic [7:0] r;
    exp_miso.push_back(exp);
    xfer_bits(8'h00, 8, r);
    got_miso.push_back(r);
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_end();
    tick(8);
    spi_cs = 1'b1;
    tick(12);
  endtask

  task automatic wait_busy_low(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk("busy_done_in_budget", {63'd0, busy}, 64'd0);
  endtask

  // Monitor: every strobe and every received byte is matched against the expected queues.
  initial begin
    busy_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_len = 0;
      end else begin
        if (mem_rd) begin
          if (exp_rd.size() == 0) unexp("mem_rd", 64'(mem_addr));
          else chk("mem_rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
        end
        if (mem_wr) begin
          if (exp_wr.size() == 0) unexp("mem_wr", 64'({mem_addr, mem_wdata}));
          else chk("mem_wr_addr_data", 64'({mem_addr, mem_wdata}), 64'(exp_wr.pop_front()));
        end
        if (erase_req) begin
          if (exp_er.size() == 0) unexp("erase_req", 64'({erase_all, erase_addr}));
          else chk("erase_all_addr", 64'({erase_all, erase_addr}), 64'(exp_er.pop_front()));
        end
        if (busy) begin
          busy_len++;
        end else if (busy_len != 0) begin
          if (exp_busy.size() == 0) unexp("busy_pulse", 64'(busy_len));
          else chk("busy_len", 64'(busy_len), 64'(exp_busy.pop_front()));
          busy_len = 0;
        end
      end
      while (got_miso.size() != 0) begin
        if (exp_miso.size() == 0) unexp("miso_byte", 64'(got_miso.pop_front()));
        else chk("miso_byte", 64'(got_miso.pop_front()), 64'(exp_miso.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [8*ID_BYTES-1:0] id_exp;
    logic [7:0]            part;

    flash_id = 160'h20BA1810_4400D01B_5C7E91A3_0FF01234_56789ABC;
    id_exp   = flash_id;
    mem[32'h12C] = 8'hA5;
    mem[32'h12D] = 8'h5A;
    mem[32'h12E] = 8'h3C;

    rst = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    tick(5);
    chk("rst_miso",       64'(miso),       64'd0);
    chk("rst_mem_addr",   64'(mem_addr),   64'd0);
    chk("rst_mem_rd",     64'(mem_rd),     64'd0);
    chk("rst_mem_wr",     64'(mem_wr),     64'd0);
    chk("rst_mem_wdata",  64'(mem_wdata),  64'd0);
    chk("rst_erase_req",  64'(erase_req),  64'd0);
    chk("rst_erase_all",  64'(erase_all),  64'd0);
    chk("rst_erase_addr", 64'(erase_addr), 64'd0);
    chk("rst_wel",        64'(wel),        64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    rst = 1'b0;
    tick(5);

    // Read ID: 20 ID bytes MSB first, then zeros.
    cs_begin();
    send(8'h9E);
    for (int i = 0; i < ID_BYTES; i++) read_chk(id_exp[8*ID_BYTES-1-8*i -: 8]);
    read_chk(8'h00);
    cs_end();

    // Read with prefetch of the byte after each one shifted out.
    exp_rd.push_back(24'h00012C);
    exp_rd.push_back(24'h00012D);
    exp_rd.push_back(24'h00012E);
    exp_rd.push_back(24'h00012F);
    cs_begin();
    send(8'h03); send(8'h00); send(8'h01); send(8'h2C);
    read_chk(8'hA5); read_chk(8'h5A); read_chk(8'h3C);
    cs_end();

    // Write enable, then page program wrapping inside the page.
    cs_begin(); send(8'h06); cs_end();
    chk("wel_after_wren", 64'(wel), 64'd1);
    exp_wr.push_back({24'h0001FE, 8'h11});
    exp_wr.push_back({24'h0001FF, 8'h22});
    exp_wr.push_back({24'h000100, 8'h33});
    exp_busy.push_back(PROG_CYC);
    cs_begin();
    send(8'h02); send(8'h00); send(8'h01); send(8'hFE);
    send(8'h11); send(8'h22); send(8'h33);
    cs_end();
    chk("busy_after_pp", 64'(busy), 64'd1);
    chk("wel_after_pp",  64'(wel),  64'd0);
    wait_busy_low(PROG_CYC + 1000);

    // Protection: program and sector erase without write enable do nothing.
    cs_begin();
    send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'hAA);
    cs_end();
    chk("busy_pp_no_wel", 64'(busy), 64'd0);
    chk("wel_pp_no_wel",  64'(wel),  64'd0);
    cs_begin();
    send(8'hD8); send(8'h00); send(8'h00); send(8'h00);
    cs_end();
    chk("busy_se_no_wel", 64'(busy), 64'd0);

    // Sector erase, and Read ID ignored while busy.
    cs_begin(); send(8'h06); cs_end();
    exp_er.push_back({1'b0, 24'h120000});
    exp_busy.push_back(SE_CYC);
    cs_begin();
    send(8'hD8); send(8'h12); send(8'h34); send(8'h56);
    cs_end();
    chk("wel_after_se", 64'(wel), 64'd0);
    cs_begin();
    send(8'h9E);
    read_chk(8'h00); read_chk(8'h00); read_chk(8'h00);
    cs_end();
    chk("busy_during_se", 64'(busy), 64'd1);
    wait_busy_low(SE_CYC + 1000);

    // Abort mid address byte: no strobes, latch kept, responder usable again.
    cs_begin(); send(8'h06); cs_end();
    cs_begin();
    send(8'h02); send(8'h00); send(8'h01);
    xfer_bits(8'hAB, 5, part);
    cs_end();
    chk("wel_after_abort",  64'(wel),  64'd1);
    chk("busy_after_abort", 64'(busy), 64'd0);
    cs_begin();
    send(8'h9E);
    read_chk(8'h20); read_chk(8'hBA);
    cs_end();

    // Bulk erase using the latch still set from before the abort.
    exp_er.push_back({1'b1, 24'h000000});
    exp_busy.push_back(BE_CYC);
    cs_begin(); send(8'hC7); cs_end();
    chk("wel_after_be", 64'(wel), 64'd0);
    wait_busy_low(BE_CYC + 1000);

    // Reset in the middle of a read.
    exp_rd.push_back(24'h00012C);
    exp_rd.push_back(24'h00012D);
    cs_begin();
    send(8'h03); send(8'h00); send(8'h01); send(8'h2C);
    read_chk(8'hA5);
    tick(3);
    rst = 1'b1;
    #1;
    chk("midrst_mem_addr",   64'(mem_addr),   64'd0);
    chk("midrst_mem_rd",     64'(mem_rd),     64'd0);
    chk("midrst_miso",       64'(miso),       64'd0);
    chk("midrst_erase_all",  64'(erase_all),  64'd0);
    chk("midrst_erase_addr", 64'(erase_addr), 64'd0);
    chk("midrst_wel",        64'(wel),        64'd0);
    chk("midrst_busy",       64'(busy),       64'd0);
    spi_cs = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(10);
    cs_begin();
    send(8'h9E);
    read_chk(8'h20);
    cs_end();
    tick(20);

    chk("left_rd",   64'(exp_rd.size()),   64'd0);
    chk("left_wr",   64'(exp_wr.size()),   64'd0);
    chk("left_er",   64'(exp_er.size()),   64'd0);
    chk("left_busy", 64'(exp_busy.size()), 64'd0);
    chk("left_miso", 64'(exp_miso.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
